// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally; a miss runs a two-state fill (IDLE/FETCH).
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | serve hits, start a fill on a miss
//   FETCH | read fill_addr from memory until iwait drops, then write the frame

module icache #(
  parameter int SETS = 16,
  parameter int TAGW = 30 - $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(SETS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [31:0]     fill_addr_q, fill_addr_d;
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [IW-1:0]   req_idx;
  logic [TAGW-1:0] req_tag;
  logic [IW-1:0]   fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            fill_done;
  logic            miss;
  logic [1:0]      unused_byte_sel;

  assign req_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign fill_idx = fill_addr_q[IW+1:2];
  assign fill_tag = fill_addr_q[31:IW+2];
  assign unused_byte_sel = imemaddr[1:0];

  // Hit detection and datapath-facing outputs; FETCH always reports no hit.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'd0;
    if (imemREN && (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
      ihit     = 1'b1;
      imemload = data_q[req_idx];
    end
  end

  assign miss      = imemREN && (state_q == IDLE) && !ihit;
  assign fill_done = (state_q == FETCH) && !iwait;

  // Memory-side outputs come only from registered state.
  assign iREN  = (state_q == FETCH);
  assign iaddr = (state_q == FETCH) ? fill_addr_q : 32'd0;

  // Next-state logic for the fill machine.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d     = FETCH;
          fill_addr_d = {imemaddr[31:2], 2'b00};
        end
      end
      FETCH: begin
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fill address and valid bits; reset abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_addr_q <= 32'd0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      if (fill_done) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Free-running, wrapping hit and miss counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (ihit) hit_count_q <= hit_count_q + 32'd1;
      if (miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of the icache fill machine and hit path.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks;
  int n_fail;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iload = 32'h0; iwait = 1'b0;
    #3;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got %0h exp 0", ihit); end
    n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload got %08h exp 0", imemload); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN got %0h exp 0", iREN); end
    n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr got %08h exp 0", iaddr); end
`ifdef ICACHE_STATS_EN
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", hit_count, miss_count); end
`endif
    imemREN = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_cold_fetch();
    imemREN = 1'b1; imemaddr = 32'h0; iload = 32'h2001_0005; iwait = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_miss_ihit got %0h exp 0", ihit); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL cold_miss_iREN got %0h exp 0", iREN); end
    tick();
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL cold_fetch_iREN got %0h exp 1", iREN); end
    n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL cold_fetch_iaddr got %08h exp 0", iaddr); end
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_fetch_ihit got %0h exp 0", ihit); end
    tick();
    n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL cold_done_ihit got %0h exp 1", ihit); end
    n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL cold_done_imemload got %08h exp 20010005", imemload); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL cold_done_iREN got %0h exp 0", iREN); end
  endtask

  task automatic test_warm_hit();
    imemREN = 1'b1; imemaddr = 32'h0000_0002; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL warm_ihit got %0h exp 1", ihit); end
    n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL warm_imemload got %08h exp 20010005", imemload); end
    tick();
    n_checks++; if (iREN !== 1'b0 || ihit !== 1'b1) begin n_fail++; $display("FAIL warm_hold got iREN=%0h ihit=%0h exp 0/1", iREN, ihit); end
    imemREN = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin n_fail++; $display("FAIL noreq got ihit=%0h load=%08h exp 0/0", ihit, imemload); end
    tick();
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL noreq_iREN got %0h exp 0", iREN); end
  endtask

  task automatic test_conflict();
    imemREN = 1'b1; imemaddr = 32'h40; iload = 32'hAAAA_0040; iwait = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_miss got %0h exp 0", ihit); end
    tick();
    n_checks++; if (iaddr !== 32'h40 || iREN !== 1'b1) begin n_fail++; $display("FAIL conflict_iaddr got %08h iREN=%0h exp 00000040/1", iaddr, iREN); end
    tick();
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA_0040) begin n_fail++; $display("FAIL conflict_hit got ihit=%0h load=%08h exp 1/aaaa0040", ihit, imemload); end
    imemaddr = 32'h0; iload = 32'h2001_0005;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL evicted_miss got %0h exp 0", ihit); end
    tick();
    n_checks++; if (iaddr !== 32'h0 || iREN !== 1'b1) begin n_fail++; $display("FAIL evicted_iaddr got %08h iREN=%0h exp 0/1", iaddr, iREN); end
    tick();
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL refill_hit got ihit=%0h load=%08h exp 1/20010005", ihit, imemload); end
  endtask

  task automatic test_stall();
    imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1; iload = 32'hBAD0_0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (iREN !== 1'b1 || ihit !== 1'b0 || iaddr !== 32'h8) begin
        n_fail++; $display("FAIL stall_cycle%0d got iREN=%0h ihit=%0h iaddr=%08h exp 1/0/00000008", i, iREN, ihit, iaddr);
      end
      iload = 32'hBAD0_0000 + 32'(i);
      tick();
    end
    iwait = 1'b0; iload = 32'h1234_5678;
    #1;
    n_checks++; if (iREN !== 1'b1 || ihit !== 1'b0) begin n_fail++; $display("FAIL stall_last got iREN=%0h ihit=%0h exp 1/0", iREN, ihit); end
    tick();
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_hit got ihit=%0h load=%08h exp 1/12345678", ihit, imemload); end
  endtask

  task automatic test_addr_change();
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1; iload = 32'h0000_0100;
    tick();
    imemaddr = 32'h8;
    #1;
    n_checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin n_fail++; $display("FAIL fetch_blocks_hit got ihit=%0h load=%08h exp 0/0", ihit, imemload); end
    n_checks++; if (iaddr !== 32'h100) begin n_fail++; $display("FAIL midfill_iaddr_a got %08h exp 00000100", iaddr); end
    tick();
    imemaddr = 32'h204; imemREN = 1'b0; iwait = 1'b0;
    #1;
    n_checks++; if (iaddr !== 32'h100 || iREN !== 1'b1) begin n_fail++; $display("FAIL midfill_iaddr_b got %08h iREN=%0h exp 00000100/1", iaddr, iREN); end
    tick();
    imemREN = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL new_addr_miss got %0h exp 0", ihit); end
    imemaddr = 32'h100;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h0000_0100) begin n_fail++; $display("FAIL old_addr_hit got ihit=%0h load=%08h exp 1/00000100", ihit, imemload); end
    imemaddr = 32'h8;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h1234_5678) begin n_fail++; $display("FAIL other_frame_hit got ihit=%0h load=%08h exp 1/12345678", ihit, imemload); end
    tick();
  endtask

  task automatic test_reset_fetch();
    imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1; iload = 32'h0000_0300;
    tick();
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rstf_pre_iREN got %0h exp 1", iREN); end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin n_fail++; $display("FAIL rstf_iREN got iREN=%0h iaddr=%08h exp 0/0", iREN, iaddr); end
`ifdef ICACHE_STATS_EN
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL rstf_counters got %0d/%0d exp 0/0", hit_count, miss_count); end
`endif
    iwait = 1'b0;
    tick();
    #2;
    nRST = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin n_fail++; $display("FAIL rstf_after_miss got ihit=%0h iREN=%0h exp 0/0", ihit, iREN); end
    imemaddr = 32'h8;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rstf_valid_cleared got %0h exp 0", ihit); end
    imemaddr = 32'h300;
    tick();
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h300) begin n_fail++; $display("FAIL rstf_refetch got iREN=%0h iaddr=%08h exp 1/00000300", iREN, iaddr); end
    tick();
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h0000_0300) begin n_fail++; $display("FAIL rstf_refill got ihit=%0h load=%08h exp 1/00000300", ihit, imemload); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cold_fetch();
    test_warm_hit();
    test_conflict();
    test_stall();
    test_addr_change();
    test_reset_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-frame instruction cache that sits immediately downstream of the pipelined datapath's fetch port and upstream of the memory controller. It answers fetch requests combinationally on a hit and runs a two-state fill machine on a miss. While the fill is in progress, `ihit` stays low, and the datapath's PC and pipeline registers hold.

## Interface
Parameters:
- `SETS`, default 16: number of frames; a power of two, at least 2. Index width `IW = log2(SETS)`.
- `TAGW`, default `30 - IW`: tag width (address bits [31:2+IW]).

Ports:
- Clock and reset: one clock, `CLK`; reset is asynchronous and active-low, `nRST`.
- `CLK` — input, 1 bit: system clock; all state updates on its rising edge.
- `nRST` — input, 1 bit: asynchronous active-low reset.
- `imemREN` — input, 1 bit: datapath fetch request.
- `imemaddr` — input, 32 bits: fetch address; bits [1:0] are ignored.
- `ihit` — output, 1 bit: `imemload` is valid this cycle.
- `imemload` — output, 32 bits: fetched instruction.
- `iREN` — output, 1 bit: read request to the memory controller.
- `iaddr` — output, 32 bits: fill address, word-aligned.
- `iload` — input, 32 bits: memory read data.
- `iwait` — input, 1 bit: memory busy; read data is valid in a cycle where `iREN` is high and `iwait` is low.

## Operation
- Address split:
  - index = `imemaddr[IW+1:2]`
  - tag = `imemaddr[31:IW+2]`
- Per frame: a valid bit, a tag of width `TAGW`, and a 32-bit data word.
- Hit: `imemREN` high, state is IDLE, the indexed frame is valid, and its tag matches. On a hit, `ihit = 1` and `imemload` = the frame's data, combinationally in the same cycle.
- Miss: `imemREN` high in IDLE without a hit.
  - On the next rising edge, latch the word-aligned `imemaddr` into `fill_addr` and go to FETCH.
- FETCH state:
  - `iREN = 1` and `iaddr = fill_addr`.
  - `ihit = 0` regardless of `imemaddr`.
  - On a rising edge with `iwait = 0`, write `iload` into frame `fill_addr` index, set its tag, set valid = 1, and return to IDLE.
- Fill data is not forwarded to the datapath. The requesting fetch hits in the cycle after the fill completes, provided `imemaddr` is unchanged.
- If `imemaddr` changes during FETCH, the fill still completes for `fill_addr`. The new address is evaluated in IDLE afterwards.
- `imemREN` low in IDLE: `ihit = 0` and no fill starts. `imemREN` dropping during FETCH does not abort the fill.
- Outputs when not hitting: `imemload` = 0. In IDLE, `iREN = 0` and `iaddr` = 0.
- Replacement: the new fill overwrites the indexed frame unconditionally.
- The cache never writes to memory and has no invalidate or flush port.

## Timing
- Reset state (asynchronous, effective immediately):
  - all valid bits = 0, state = IDLE, `fill_addr` = 0
  - outputs: `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0
  - the tag and data arrays need not be reset
- Reset asserted during FETCH: `iREN` drops the same instant, the fill is abandoned, and the frame stays invalid.
- Hit latency: 0 cycles, combinational from `imemaddr`.
- Miss penalty: 1 cycle (IDLE→FETCH) + N cycles with `iwait` = 1 + 1 completion edge, then a hit in IDLE. With `iwait` always low, `ihit` rises exactly 2 cycles after the miss cycle.
- `iREN` and `iaddr` are driven only from registered state, with no combinational path from `imemaddr`.

## Configuration
- Macro: `ICACHE_STATS_EN`.
- Defined:
  - Adds output ports `hit_count` [31:0] and `miss_count` [31:0], both reset to 0.
  - `hit_count` increments on each rising edge where `ihit` = 1.
  - `miss_count` increments on each IDLE→FETCH transition.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Cold fetch: reset, then `imemREN` = 1, `imemaddr` = 0x0000_0000, memory returns 0x2001_0005 with `iwait` low.
  - Required: `iREN` high one cycle later with `iaddr` = 0; `ihit` = 1 and `imemload` = 0x2001_0005 two cycles after the miss.
- Warm hit: repeat the fetch of 0x0.
  - Required: `ihit` = 1 in the same cycle, `iREN` stays 0.
- Conflict eviction (`SETS` = 16): fill 0x0000_0000, then fetch 0x0000_0040 (same index, different tag).
  - Required: a miss with `iaddr` = 0x40. A later fetch of 0x0 misses again.
- Memory stall: a miss with `iwait` held high for 5 cycles.
  - Required: `iREN` = 1 and `ihit` = 0 throughout; the frame is written only on the first edge with `iwait` low.
- Address change mid-fill: miss on 0x100, then `imemaddr` changes to 0x204 during FETCH.
  - Required: `iaddr` stays 0x100; after completion, 0x204 misses and 0x100 hits.
- Reset during FETCH: assert `nRST` low while `iREN` = 1.
  - Required: `iREN` = 0 immediately. After release, the original address misses. With `ICACHE_STATS_EN`, both counters read 0.
